counters_monitor: RTL and testbench

COUNTERS_MONITOR -- requirements
Module: counters_monitor

---
 rtl/counters_monitor.sv | 193 +++++++++++++++++++
 tb/tb_counters_monitor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/counters_monitor.sv
// counters_monitor
// ----------------
// Watches the summed output of a four-counter bank and checks it against
// four locally kept shadow counters.
//   s1 : SIZE bits, s2/s3 : SIZE/2 bits, s4 : SIZE/8 bits, each wrapping.
// Every valid sample advances the shadow selected by `phase` (round robin
// s1,s2,s3,s4). The post-increment sum of the shadows is compared with the
// incoming sum. The monitor locks onto the stream when it sees a zero sum.
// It drops lock on the first mismatch and hunts for the next zero sum.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   in_sum carries a sample this cycle
//   in_sum     in   [2*SIZE-1:0] summed counter-bank value under check
//   clr        in   synchronous clear of err_sticky / err_cnt
//   locked     out  monitor is tracking the stream
//   err        out  one-cycle pulse after a mismatched sample
//   err_sticky out  set by any mismatch, held until clr or rst
//   err_cnt    out  [7:0] saturating mismatch count
//   phase      out  [1:0] shadow counter advanced by the next sample
//
// Build option
//   COUNTERS_MONITOR_RESYNC_EN : when defined, a mismatched zero-sum sample
//   seen while locked counts as a source reset. The monitor relocks silently.
//
// Parameter SIZE must be a multiple of 8 and >= 8.

module counters_monitor #(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2*SIZE-1:0] in_sum,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic              err_sticky,
  output logic [7:0]        err_cnt,
  output logic [1:0]        phase
);

  localparam int W1 = SIZE;
  localparam int W2 = SIZE / 2;
  localparam int W4 = SIZE / 8;
  localparam int SW = 2 * SIZE;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOCK = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W1-1:0]   s1_q, s1_d, s1_n;
  logic [W2-1:0]   s2_q, s2_d, s2_n;
  logic [W2-1:0]   s3_q, s3_d, s3_n;
  logic [W4-1:0]   s4_q, s4_d, s4_n;
  logic [1:0]      phase_q, phase_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic            sticky_q, sticky_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [SW-1:0]   exp_sum_s;
  logic            mismatch_s;
  logic            sum_zero_s;

  // Post-increment shadow candidates and the expected sum they produce.
  always_comb begin
    s1_n = s1_q;
    s2_n = s2_q;
    s3_n = s3_q;
    s4_n = s4_q;
    case (phase_q)
      2'd0:    s1_n = s1_q + W1'(1'b1);
      2'd1:    s2_n = s2_q + W2'(1'b1);
      2'd2:    s3_n = s3_q + W2'(1'b1);
      2'd3:    s4_n = s4_q + W4'(1'b1);
      default: s1_n = s1_q;
    endcase
    exp_sum_s  = SW'(s1_n) + SW'(s2_n) + SW'(s3_n) + SW'(s4_n);
    sum_zero_s = (in_sum == {SW{1'b0}});
  end

  // Next-state, shadow, phase and error bookkeeping.
  always_comb begin
    state_d    = state_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    s3_d       = s3_q;
    s4_d       = s4_q;
    phase_d    = phase_q;
    err_d      = 1'b0;
    mismatch_s = 1'b0;
    case (state_q)
      HUNT, FAIL: begin
        if (in_valid && sum_zero_s) begin
          state_d = LOCK;
          s1_d    = {W1{1'b0}};
          s2_d    = {W2{1'b0}};
          s3_d    = {W2{1'b0}};
          s4_d    = {W4{1'b0}};
          phase_d = 2'd0;
        end else begin
          state_d = state_q;
        end
      end
      LOCK: begin
        if (in_valid) begin
          s1_d    = s1_n;
          s2_d    = s2_n;
          s3_d    = s3_n;
          s4_d    = s4_n;
          phase_d = phase_q + 2'd1;
          if (exp_sum_s != in_sum) begin
`ifdef COUNTERS_MONITOR_RESYNC_EN
            if (sum_zero_s) begin
              // Source counters were reset: follow them without flagging.
              s1_d    = {W1{1'b0}};
              s2_d    = {W2{1'b0}};
              s3_d    = {W2{1'b0}};
              s4_d    = {W4{1'b0}};
              phase_d = 2'd0;
            end else begin
              mismatch_s = 1'b1;
              err_d      = 1'b1;
              state_d    = FAIL;
            end
`else
            mismatch_s = 1'b1;
            err_d      = 1'b1;
            state_d    = FAIL;
`endif
          end else begin
            state_d = LOCK;
          end
        end else begin
          state_d = LOCK;
        end
      end
      default: state_d = HUNT;
    endcase

    // Clear beats a simultaneous mismatch for the sticky flag and counter.
    if (clr) begin
      sticky_d = 1'b0;
      cnt_d    = 8'd0;
    end else if (mismatch_s) begin
      sticky_d = 1'b1;
      cnt_d    = (cnt_q == 8'd255) ? cnt_q : cnt_q + 8'd1;
    end else begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
    end

    locked_d = (state_d == LOCK);
  end

  // State and output registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      s1_q     <= {W1{1'b0}};
      s2_q     <= {W2{1'b0}};
      s3_q     <= {W2{1'b0}};
      s4_q     <= {W4{1'b0}};
      phase_q  <= 2'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      s4_q     <= s4_d;
      phase_q  <= phase_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_counters_monitor.sv
module tb_counters_monitor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_sum;
  logic        clr;
  logic        locked;
  logic        err;
  logic        err_sticky;
  logic [7:0]  err_cnt;
  logic [1:0]  phase;

  int checks = 0;
  int errors = 0;

  counters_monitor #(.SIZE(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sum     (in_sum),
    .clr        (clr),
    .locked     (locked),
    .err        (err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one sample at the falling edge; return 1 time unit after capture.
  task automatic send(input logic [15:0] v, input logic c);
    @(negedge clk);
    in_valid = 1'b1;
    in_sum   = v;
    clr      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected bank sum after k samples since lock (SIZE=8 widths).
  function automatic logic [15:0] exp_at(input int k);
    int a, b, c, d;
    a = ((k + 3) / 4) % 256;
    b = ((k + 2) / 4) % 16;
    c = ((k + 1) / 4) % 16;
    d = (k / 4) % 2;
    return 16'(a + b + c + d);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sum = 16'd0;
    clr = 1'b0;
    #12;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b exp 0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %0b exp 0", err_sticky); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", err_cnt); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count();
    logic [15:0] vals [8];
    vals = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd6};
    do_reset();
    send(16'd0, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL count_lock got %0b exp 1", locked); end
    for (int i = 0; i < 8; i++) begin
      send(vals[i], 1'b0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL count_err[%0d] got %0b exp 0", i, err); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL count_locked[%0d] got %0b exp 1", i, locked); end
      checks++; if (phase !== 2'((i + 1) % 4)) begin errors++; $display("FAIL count_phase[%0d] got %0d exp %0d", i, phase, (i + 1) % 4); end
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    send(16'd5, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL hunt_ignore got %0b exp 0", locked); end
    send(16'd0, 1'b0);
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    send(16'd9, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mm_err got %0b exp 1", err); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL mm_sticky got %0b exp 1", err_sticky); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL mm_cnt got %0d exp 1", err_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mm_locked got %0b exp 0", locked); end
    idle(1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mm_pulse_end got %0b exp 0", err); end
    send(16'd3, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fail_no_err got %0b exp 0", err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL fail_cnt got %0d exp 1", err_cnt); end
    send(16'd0, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got %0b exp 1", locked); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL relock_sticky got %0b exp 1", err_sticky); end
  endtask

  task automatic test_wrap();
    do_reset();
    send(16'd0, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      send(exp_at(k), 1'b0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err[%0d] got %0b exp 0", k, err); end
    end
    send(16'd17, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_65 got %0b exp 0", err); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked got %0b exp 1", locked); end
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL wrap_phase got %0d exp 1", phase); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(16'd0, 1'b0);
      send(16'd5, 1'b0);
      if (i == 9) begin
        checks++; if (err_cnt !== 8'd10) begin errors++; $display("FAIL sat_cnt10 got %0d exp 10", err_cnt); end
      end
    end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d exp 255", err_cnt); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky got %0b exp 1", err_sticky); end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", err_cnt); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got %0b exp 0", err_sticky); end
  endtask

  task automatic test_clr_collision();
    do_reset();
    send(16'd0, 1'b0);
    send(16'd9, 1'b0);
    send(16'd0, 1'b0);
    send(16'd1, 1'b0);
    send(16'd7, 1'b1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL coll_err got %0b exp 1", err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL coll_cnt got %0d exp 0", err_cnt); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL coll_sticky got %0b exp 0", err_sticky); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL coll_locked got %0b exp 0", locked); end
  endtask

  task automatic test_resync();
    do_reset();
    send(16'd0, 1'b0);
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    send(16'd0, 1'b0);
`ifdef COUNTERS_MONITOR_RESYNC_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL resync_err got %0b exp 0", err); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL resync_locked got %0b exp 1", locked); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL resync_phase got %0d exp 0", phase); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL resync_cnt got %0d exp 0", err_cnt); end
    send(16'd1, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL resync_next got %0b exp 0", err); end
`else
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL resync_err got %0b exp 1", err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL resync_cnt got %0d exp 1", err_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL resync_locked got %0b exp 0", locked); end
`endif
  endtask

  task automatic test_gaps_and_reset();
    do_reset();
    send(16'd0, 1'b0);
    send(16'd1, 1'b0);
    idle(3);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL gap_phase got %0d exp 1", phase); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_locked got %0b exp 1", locked); end
    send(16'd2, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL gap_next got %0b exp 0", err); end
    send(16'd9, 1'b0);
    send(16'd0, 1'b0);
    send(16'd1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_locked got %0b exp 0", locked); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL arst_phase got %0d exp 0", phase); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL arst_sticky got %0b exp 0", err_sticky); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", err_cnt); end
    @(negedge clk);
    rst = 1'b0;
    send(16'd1, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL post_rst_hunt got %0b exp 0", locked); end
    send(16'd0, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL post_rst_lock got %0b exp 1", locked); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_mismatch();
    test_wrap();
    test_saturate();
    test_clr_collision();
    test_resync();
    test_gaps_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
